// File: rtl/and_or_unit.sv
// Registered bitwise AND/OR unit: one accepted operand pair per cycle, results one clock later.
// Optional x_xor_y result is present when ANDOR_XOR_EN is defined.
module and_or_unit #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  output logic [WIDTH-1:0] x_and_y,
  output logic [WIDTH-1:0] x_or_y,
  output logic             and_any,
  output logic             or_all
`ifdef ANDOR_XOR_EN
  ,
  output logic [WIDTH-1:0] x_xor_y
`endif
);

  // Handshake: out_valid is a one-cycle pulse per accepted pair; there is no
  // backpressure, so the consumer must sample results while out_valid is high.

  logic             valid_q,   valid_d;
  logic [WIDTH-1:0] and_q,     and_d;
  logic [WIDTH-1:0] or_q,      or_d;
  logic             any_q,     any_d;
  logic             all_q,     all_d;
`ifdef ANDOR_XOR_EN
  logic [WIDTH-1:0] xor_q,     xor_d;
`endif

  // Results hold their last values whenever no new pair is accepted.
  always_comb begin
    valid_d = in_valid;
    and_d   = and_q;
    or_d    = or_q;
    any_d   = any_q;
    all_d   = all_q;
`ifdef ANDOR_XOR_EN
    xor_d   = xor_q;
`endif
    if (in_valid) begin
      and_d = x & y;
      or_d  = x | y;
      any_d = |(x & y);
      all_d = &(x | y);
`ifdef ANDOR_XOR_EN
      xor_d = x ^ y;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      and_q   <= '0;
      or_q    <= '0;
      any_q   <= 1'b0;
      all_q   <= 1'b0;
`ifdef ANDOR_XOR_EN
      xor_q   <= '0;
`endif
    end else begin
      valid_q <= valid_d;
      and_q   <= and_d;
      or_q    <= or_d;
      any_q   <= any_d;
      all_q   <= all_d;
`ifdef ANDOR_XOR_EN
      xor_q   <= xor_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign x_and_y   = and_q;
  assign x_or_y    = or_q;
  assign and_any   = any_q;
  assign or_all    = all_q;
`ifdef ANDOR_XOR_EN
  assign x_xor_y   = xor_q;
`endif

endmodule

// File: tb/tb_and_or_unit.sv
// Self-checking bench for and_or_unit (WIDTH=2 scoreboard plus a WIDTH=8 instance).
// Expected packing: {and[1:0], or[1:0], and_any, or_all, xor[1:0]}.
module tb_and_or_unit;

  localparam int EW = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic       in_valid;
  logic [1:0] x, y;
  logic       out_valid;
  logic [1:0] x_and_y, x_or_y;
  logic       and_any, or_all;
`ifdef ANDOR_XOR_EN
  logic [1:0] x_xor_y;
`endif

  logic       in_valid8;
  logic [7:0] x8, y8;
  logic       out_valid8;
  logic [7:0] x_and_y8, x_or_y8;
  logic       and_any8, or_all8;
`ifdef ANDOR_XOR_EN
  logic [7:0] x_xor_y8;
`endif

  and_or_unit #(.WIDTH(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .x(x), .y(y),
    .out_valid(out_valid), .x_and_y(x_and_y), .x_or_y(x_or_y),
    .and_any(and_any), .or_all(or_all)
`ifdef ANDOR_XOR_EN
    , .x_xor_y(x_xor_y)
`endif
  );

  and_or_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .x(x8), .y(y8),
    .out_valid(out_valid8), .x_and_y(x_and_y8), .x_or_y(x_or_y8),
    .and_any(and_any8), .or_all(or_all8)
`ifdef ANDOR_XOR_EN
    , .x_xor_y(x_xor_y8)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [EW-1:0] exp_q[$];
  int            due_q[$];
  int            neg_cnt = 0;
  int            n_vec   = 0;
  int            n_fail  = 0;
  logic          exp_v;
  logic [EW-1:0] e;

  // Hand-computed results for x = i[3:2], y = i[1:0].
  logic [EW-1:0] tab [16] = '{
    8'b00_00_0_0_00, 8'b00_01_0_0_01, 8'b00_10_0_0_10, 8'b00_11_0_1_11,
    8'b00_01_0_0_01, 8'b01_01_1_0_00, 8'b00_11_0_1_11, 8'b01_11_1_1_10,
    8'b00_10_0_0_10, 8'b00_11_0_1_11, 8'b10_10_1_0_00, 8'b10_11_1_1_01,
    8'b00_11_0_1_11, 8'b01_11_1_1_10, 8'b10_11_1_1_01, 8'b11_11_1_1_00
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      while (due_q.size() > 0 && due_q[0] < neg_cnt) begin
        n_vec++; n_fail++;
        $display("FAIL late_result: got none expected %0h (t=%0t)", exp_q[0], $time);
        void'(exp_q.pop_front());
        void'(due_q.pop_front());
      end
      exp_v = (due_q.size() > 0 && due_q[0] == neg_cnt);
      chk("out_valid", {31'd0, out_valid}, {31'd0, exp_v});
      if (exp_v) begin
        e = exp_q.pop_front();
        void'(due_q.pop_front());
        if (out_valid === 1'b1) begin
          chk("x_and_y", {30'd0, x_and_y}, {30'd0, e[7:6]});
          chk("x_or_y",  {30'd0, x_or_y},  {30'd0, e[5:4]});
          chk("and_any", {31'd0, and_any}, {31'd0, e[3]});
          chk("or_all",  {31'd0, or_all},  {31'd0, e[2]});
`ifdef ANDOR_XOR_EN
          chk("x_xor_y", {30'd0, x_xor_y}, {30'd0, e[1:0]});
`endif
        end
      end
    end
    neg_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] xv, input logic [1:0] yv, input logic [EW-1:0] ev);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    x = xv;
    y = yv;
    exp_q.push_back(ev);
    due_q.push_back(neg_cnt + 1);
  endtask

  task automatic idle(input logic [1:0] xv, input logic [1:0] yv);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = xv;
    y = yv;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ov"},  {31'd0, out_valid},  32'd0);
    chk({tag, "_and"}, {30'd0, x_and_y},    32'd0);
    chk({tag, "_or"},  {30'd0, x_or_y},     32'd0);
    chk({tag, "_any"}, {31'd0, and_any},    32'd0);
    chk({tag, "_all"}, {31'd0, or_all},     32'd0);
    chk({tag, "_ov8"}, {31'd0, out_valid8}, 32'd0);
    chk({tag, "_and8"}, {24'd0, x_and_y8},  32'd0);
    chk({tag, "_or8"},  {24'd0, x_or_y8},   32'd0);
`ifdef ANDOR_XOR_EN
    chk({tag, "_xor"}, {30'd0, x_xor_y},    32'd0);
`endif
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b1; x = 2'b11; y = 2'b11;
    in_valid8 = 1'b1; x8 = 8'hFF; y8 = 8'hFF;

    // Reset held with valid operands present.
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("rst_hold");
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0; in_valid8 = 1'b0;

    // Exhaustive back-to-back pairs.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] iv;
      iv = 4'(i);
      issue(iv[3:2], iv[1:0], tab[i]);
    end
    idle(2'b00, 2'b00);
    idle(2'b00, 2'b00);

    // Hold: results persist while in_valid is low.
    issue(2'b11, 2'b01, 8'b01_11_1_1_10);
    repeat (3) idle(2'b00, 2'b00);
    @(negedge clk);
    chk("hold_and", {30'd0, x_and_y}, 32'h1);
    chk("hold_or",  {30'd0, x_or_y},  32'h3);
    chk("hold_any", {31'd0, and_any}, 32'h1);
    chk("hold_all", {31'd0, or_all},  32'h1);

    // Async reset between edges with a pair in flight.
    issue(2'b01, 2'b01, 8'b01_01_1_0_00);
    issue(2'b10, 2'b10, 8'b10_10_1_0_00);
    @(posedge clk);
    #2;
    rst_n = 1'b0; in_valid = 1'b0;
    exp_q.delete();
    due_q.delete();
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) idle(2'b11, 2'b11);
    @(negedge clk);
    chk("post_rst_ov", {31'd0, out_valid}, 32'd0);

    // WIDTH=8 instance.
    @(posedge clk);
    #1;
    in_valid8 = 1'b1; x8 = 8'hF0; y8 = 8'h3C;
    @(posedge clk);
    #1;
    in_valid8 = 1'b0; x8 = 8'h00; y8 = 8'h00;
    chk("w8_ov",  {31'd0, out_valid8}, 32'd1);
    chk("w8_and", {24'd0, x_and_y8},   32'h30);
    chk("w8_or",  {24'd0, x_or_y8},    32'hFC);
    chk("w8_any", {31'd0, and_any8},   32'd1);
    chk("w8_all", {31'd0, or_all8},    32'd0);
`ifdef ANDOR_XOR_EN
    chk("w8_xor", {24'd0, x_xor_y8},   32'hCC);
`endif
    @(posedge clk);
    #1;
    chk("w8_ov_drop", {31'd0, out_valid8}, 32'd0);
    chk("w8_and_hold", {24'd0, x_and_y8}, 32'h30);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
